// File: rtl/tetris_pkg.sv
// Shared board geometry, colour-index width, FSM state type and the
// 8-entry colour palette used by the playfield renderer.
//   COLS/ROWS  : board size in cells
//   COLOR_W    : width of a cell colour index (0 = empty)
//   ADDR_W     : board RAM address width (row*COLS+col)
//   palette_rgb: colour index -> 12-bit 4:4:4 colour
//   cell_addr  : (row, col) -> linear board address, shift/add only
package tetris_pkg;

  localparam int COLS    = 10;
  localparam int ROWS    = 20;
  localparam int CELLS   = COLS * ROWS;
  localparam int COLOR_W = 3;
  localparam int ADDR_W  = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } fsm_state_e;

  // Entries 1..7: cyan, yellow, purple, green, red, blue, orange.
  function automatic logic [11:0] palette_rgb(input logic [COLOR_W-1:0] idx);
    logic [11:0] c;
    case (idx)
      3'd1:    c = 12'h0FF;
      3'd2:    c = 12'hFF0;
      3'd3:    c = 12'h80F;
      3'd4:    c = 12'h0F0;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      3'd7:    c = 12'hF80;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  // row*10 + col computed as (row<<3) + (row<<1) + col.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row,
                                                  input logic [3:0] col);
    return ({3'b000, row} << 3) + ({3'b000, row} << 1) + {4'b0000, col};
  endfunction

endpackage

// File: rtl/board_ram.sv
// Board storage: one write port, one synchronous read port, read-first.
//   clk, rst           : clock, async active-low reset (read register only)
//   we, waddr, wdata   : write port
//   raddr, rdata       : read port, data valid the cycle after raddr
// The array itself is not reset; the renderer's clear sweep empties it.
module board_ram #(
  parameter int DEPTH = 200,
  parameter int WIDTH = 3,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Non-blocking read of the array returns the pre-write value on a
  // same-address collision (read-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rdata <= '0;
    else      r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/playfield_render.sv
// Tetris playfield renderer: maps VGA pixel coordinates onto a 10x20 board,
// draws a 2-pixel border, and outputs the pixel colour with syncs aligned.
//   clk, rst                 : pixel clock, async active-low reset
//   pixel_x/y, video_on      : coordinates and active flag from sync gen
//   hsync, vsync             : active-low syncs from sync gen
//   wr_en/col/row/color      : board cell write (ignored while busy)
//   clear                    : request to empty the board (clear sweep)
//   busy                     : clear sweep in progress
//   rgb, hsync_o, vsync_o    : colour and syncs, 2 clocks after inputs
//   frame_tick               : pulse after vsync falling edge is sampled
//   dbg_state                : FSM state (0 = CLEAR, 1 = RUN)
module playfield_render
  import tetris_pkg::*;
#(
  parameter int X0      = 240,
  parameter int Y0      = 80,
  parameter int CELL_PX = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [9:0]   pixel_x,
  input  logic [9:0]   pixel_y,
  input  logic         video_on,
  input  logic         hsync,
  input  logic         vsync,
  input  logic         wr_en,
  input  logic [3:0]   wr_col,
  input  logic [4:0]   wr_row,
  input  logic [2:0]   wr_color,
  input  logic         clear,
  output logic         busy,
  output logic [11:0]  rgb,
  output logic         hsync_o,
  output logic         vsync_o,
  output logic         frame_tick,
  output logic         dbg_state
);

  localparam int          SH        = $clog2(CELL_PX);
  localparam int          FW        = COLS * CELL_PX;
  localparam int          FH        = ROWS * CELL_PX;
  localparam logic [10:0] FX_LO     = 11'(X0);
  localparam logic [10:0] FX_HI     = 11'(X0 + FW);
  localparam logic [10:0] FY_LO     = 11'(Y0);
  localparam logic [10:0] FY_HI     = 11'(Y0 + FH);
  localparam logic [10:0] BX_LO     = 11'(X0 - 2);
  localparam logic [10:0] BX_HI     = 11'(X0 + FW + 2);
  localparam logic [10:0] BY_LO     = 11'(Y0 - 2);
  localparam logic [10:0] BY_HI     = 11'(Y0 + FH + 2);
  localparam logic [9:0]  CELL_MASK = 10'(CELL_PX - 1);

  fsm_state_e        r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_busy;

  // Stage 1 registers
  logic r1_video_on, r1_in_field, r1_border, r1_edge, r1_mask;
  logic r1_hsync, r1_vsync;
  // Stage 2 registers
  logic [11:0] r_rgb;
  logic        r_hsync2, r_vsync2, r_frame_tick;

  logic [10:0]        w_px, w_py;
  logic [9:0]         w_dx, w_dy;
  logic               w_in_field, w_border, w_edge;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic               w_user_ok, w_we;
  logic [ADDR_W-1:0]  w_waddr;
  logic [COLOR_W-1:0] w_wdata, w_ram_rdata, w_cell;
  logic [11:0]        w_rgb_next;

  // ---------------- address mapping (stage 1 combinational) -------------
  assign w_px = {1'b0, pixel_x};
  assign w_py = {1'b0, pixel_y};
  assign w_dx = pixel_x - 10'(X0);
  assign w_dy = pixel_y - 10'(Y0);

  assign w_in_field = video_on && (w_px >= FX_LO) && (w_px < FX_HI)
                               && (w_py >= FY_LO) && (w_py < FY_HI);
  assign w_border   = video_on && !w_in_field
                   && (w_px >= BX_LO) && (w_px < BX_HI)
                   && (w_py >= BY_LO) && (w_py < BY_HI);
  assign w_edge     = ((w_dx & CELL_MASK) == 10'd0) || ((w_dy & CELL_MASK) == 10'd0);
  // Outside the field the read address is parked at 0 to stay in range.
  assign w_rd_addr  = w_in_field ? cell_addr(5'(w_dy >> SH), 4'(w_dx >> SH)) : '0;

  // ---------------- write port: sweep owns it while clearing ------------
  assign w_user_ok = wr_en && (wr_col < 4'(COLS)) && (wr_row < 5'(ROWS)) && !r_busy;
  assign w_we      = (r_state == ST_CLEAR) || w_user_ok;
  assign w_waddr   = (r_state == ST_CLEAR) ? r_clr_addr : cell_addr(wr_row, wr_col);
  assign w_wdata   = (r_state == ST_CLEAR) ? '0 : wr_color;

  board_ram #(
    .DEPTH (CELLS),
    .WIDTH (COLOR_W)
  ) u_board_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (w_rd_addr),
    .rdata (w_ram_rdata)
  );

  // ---------------- clear FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_busy     <= 1'b1;
    end else if (clear) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_addr == ADDR_W'(CELLS - 1)) begin
            r_state    <= ST_RUN;
            r_clr_addr <= '0;
            r_busy     <= 1'b0;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- stage 1 ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_video_on <= 1'b0;
      r1_in_field <= 1'b0;
      r1_border   <= 1'b0;
      r1_edge     <= 1'b0;
      r1_mask     <= 1'b0;
      r1_hsync    <= 1'b1;
      r1_vsync    <= 1'b1;
    end else begin
      r1_video_on <= video_on;
      r1_in_field <= w_in_field;
      r1_border   <= w_border;
      r1_edge     <= w_edge;
      r1_mask     <= r_busy;
      r1_hsync    <= hsync;
      r1_vsync    <= vsync;
    end
  end

  // ---------------- stage 2 colour select ----------------
  always_comb begin
    // While clearing, stale RAM contents must not show through.
    w_cell     = r1_mask ? '0 : w_ram_rdata;
    w_rgb_next = 12'h000;
    if (!r1_video_on) begin
      w_rgb_next = 12'h000;
    end else if (r1_border) begin
      w_rgb_next = 12'hFFF;
    end else if (r1_in_field) begin
      if (w_cell == '0) w_rgb_next = r1_edge ? 12'h333 : 12'h222;
      else              w_rgb_next = palette_rgb(w_cell);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb        <= 12'h000;
      r_hsync2     <= 1'b1;
      r_vsync2     <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_rgb        <= w_rgb_next;
      r_hsync2     <= r1_hsync;
      r_vsync2     <= r1_vsync;
      // r1_vsync is the previous vsync sample: high then low -> tick.
      r_frame_tick <= r1_vsync && !vsync;
    end
  end

  assign rgb        = r_rgb;
  assign hsync_o    = r_hsync2;
  assign vsync_o    = r_vsync2;
  assign frame_tick = r_frame_tick;
  assign busy       = r_busy;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_playfield_render.sv
module tb_playfield_render;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        video_on = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_col = '0;
  logic [4:0]  wr_row = '0;
  logic [2:0]  wr_color = '0;
  logic        clear = 1'b0;
  logic        busy;
  logic [11:0] rgb;
  logic        hsync_o, vsync_o, frame_tick, dbg_state;

  always #5 clk = ~clk;

  playfield_render dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .hsync      (hsync),
    .vsync      (vsync),
    .wr_en      (wr_en),
    .wr_col     (wr_col),
    .wr_row     (wr_row),
    .wr_color   (wr_color),
    .clear      (clear),
    .busy       (busy),
    .rgb        (rgb),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {rgb, hsync, vsync} expected 2 clocks after drive.
  logic [13:0] exp_q[$];
  logic [19:0] tag_q[$];

  // Reference model state
  logic [2:0] board_m [200];
  int         m_busy_cnt;   // posedges still to come with busy sampled high
  logic       m_vs_last;
  logic       m_tick_exp;

  function automatic logic [11:0] tb_palette(input logic [2:0] c);
    case (c)
      3'd1: return 12'h0FF;
      3'd2: return 12'hFF0;
      3'd3: return 12'h80F;
      3'd4: return 12'h0F0;
      3'd5: return 12'hF00;
      3'd6: return 12'h00F;
      3'd7: return 12'hF80;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y,
                                            input logic von, input logic msk);
    logic in_f;
    int c, r;
    logic [2:0] v;
    if (!von) return 12'h000;
    in_f = (x >= 240) && (x < 400) && (y >= 80) && (y < 400);
    if (!in_f && x >= 238 && x < 402 && y >= 78 && y < 402) return 12'hFFF;
    if (!in_f) return 12'h000;
    c = (x - 240) / 16;
    r = (y - 80) / 16;
    v = msk ? 3'd0 : board_m[r * 10 + c];
    if (v == 3'd0) return (((x - 240) % 16 == 0) || ((y - 80) % 16 == 0)) ? 12'h333 : 12'h222;
    return tb_palette(v);
  endfunction

  task automatic init_model();
    exp_q.delete();
    tag_q.delete();
    foreach (board_m[i]) board_m[i] = 3'd0;
    m_busy_cnt = 200;
    m_vs_last  = 1'b1;
    m_tick_exp = 1'b0;
  endtask

  // One clock: check what is due now, then drive the next inputs.
  task automatic step(input int x, input int y, input logic von, input logic hs,
                      input logic vs, input logic we, input int wc, input int wrw,
                      input logic [2:0] wcolor, input logic clr);
    logic [13:0] e;
    logic [19:0] t;
    logic [11:0] rgb_e;
    logic        busy_e;
    @(negedge clk);
    if (m_busy_cnt > 0) m_busy_cnt--;
    busy_e = (m_busy_cnt > 0);
    n_checks++;
    if (busy !== busy_e) begin
      n_fail++;
      $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, busy_e);
    end
    n_checks++;
    if (frame_tick !== m_tick_exp) begin
      n_fail++;
      $display("FAIL frame_tick t=%0t got=%b exp=%b", $time, frame_tick, m_tick_exp);
    end
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      if (rgb !== e[13:2]) begin
        n_fail++;
        $display("FAIL rgb x=%0d y=%0d got=%h exp=%h", t[19:10], t[9:0], rgb, e[13:2]);
      end
      n_checks++;
      if (hsync_o !== e[1] || vsync_o !== e[0]) begin
        n_fail++;
        $display("FAIL sync_out t=%0t got=%b%b exp=%b%b", $time, hsync_o, vsync_o, e[1], e[0]);
      end
    end
    rgb_e = model_rgb(x, y, von, busy_e);
    exp_q.push_back({rgb_e, hs, vs});
    tag_q.push_back({10'(x), 10'(y)});
    m_tick_exp = m_vs_last && !vs;
    m_vs_last  = vs;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    hsync    = hs;
    vsync    = vs;
    wr_en    = we;
    wr_col   = 4'(wc);
    wr_row   = 5'(wrw);
    wr_color = wcolor;
    clear    = clr;
    if (we && wc < 10 && wrw < 20 && !busy_e) board_m[wrw * 10 + wc] = wcolor;
    if (clr) begin
      foreach (board_m[i]) board_m[i] = 3'd0;
      m_busy_cnt = 201;
    end
  endtask

  task automatic px(input int x, input int y);
    step(x, y, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3'd0, 1'b0);
  endtask

  task automatic wr(input int c, input int r, input logic [2:0] col);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, c, r, col, 1'b0);
  endtask

  task automatic rand_px();
    px($urandom_range(230, 410), $urandom_range(70, 410));
  endtask

  task automatic scan_board();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) begin
        px(240 + c * 16, 80 + r * 16);
        px(240 + c * 16 + 5, 80 + r * 16 + 7);
      end
  endtask

  task automatic set_idle();
    video_on = 1'b0; hsync = 1'b1; vsync = 1'b1;
    wr_en = 1'b0; clear = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (rgb !== 12'h000) begin n_fail++; $display("FAIL %s_rgb got=%h exp=000", tag, rgb); end
    n_checks++;
    if (hsync_o !== 1'b1 || vsync_o !== 1'b1) begin
      n_fail++; $display("FAIL %s_sync got=%b%b exp=11", tag, hsync_o, vsync_o);
    end
    n_checks++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL %s_tick got=%b exp=0", tag, frame_tick); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy got=%b exp=1", tag, busy); end
  endtask

  // Counts posedges that see busy high after a reset release.
  task automatic test_sweep_after_reset(input string tag);
    int hi;
    hi = busy ? 1 : 0;
    for (int i = 0; i < 210; i++) begin
      rand_px();
      if (busy) hi++;
    end
    n_checks++;
    if (hi != 200) begin n_fail++; $display("FAIL %s_busy_len got=%0d exp=200", tag, hi); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    pixel_x = 10'd300; pixel_y = 10'd100; video_on = 1'b1; hsync = 1'b0; vsync = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    set_idle();
    @(negedge clk);
    rst = 1'b1;
    init_model();
  endtask

  task automatic test_write_basic();
    wr(0, 0, 3'd1);
    px(240, 80);
    px(255, 95);
    px(256, 80);
    wr(9, 19, 3'd7);
    wr(5, 10, 3'd3);
    px(240 + 9 * 16 + 8, 80 + 19 * 16 + 8);
    px(240 + 5 * 16 + 1, 80 + 10 * 16 + 1);
    // Write and read the same cell in one cycle: old data must come back.
    step(240 + 2 * 16 + 3, 80 + 3 * 16 + 4, 1'b1, 1'b1, 1'b1, 1'b1, 2, 3, 3'd5, 1'b0);
    px(240 + 2 * 16 + 3, 80 + 3 * 16 + 4);
    for (int i = 0; i < 25; i++)
      wr($urandom_range(0, 9), $urandom_range(0, 19), 3'($urandom_range(0, 7)));
    scan_board();
  endtask

  task automatic test_bad_writes();
    wr(10, 0, 3'd5);
    wr(15, 3, 3'd2);
    wr(0, 20, 3'd4);
    wr(3, 31, 3'd6);
    scan_board();
  endtask

  task automatic test_border();
    px(238, 80);
    px(400, 399);
    px(237, 80);
    px(239, 78);
    px(401, 401);
    px(402, 200);
    px(300, 77);
    px(399, 399);
    step(300, 240, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 3'd0, 1'b0);
    step(238, 80, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 3'd0, 1'b0);
    px(300, 240);
  endtask

  task automatic test_clear_restart();
    int hi;
    wr(4, 4, 3'd2);
    step(300, 150, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3'd0, 1'b1);
    // The clear step leaves the sweep address at 0; 100 steps later it is 100.
    for (int i = 0; i < 99; i++) begin
      if (i % 10 == 3) wr($urandom_range(0, 9), $urandom_range(0, 19), 3'($urandom_range(1, 7)));
      else rand_px();
    end
    step(300, 150, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3'd0, 1'b1);
    hi = 0;
    for (int i = 0; i < 205; i++) begin
      if (i % 17 == 5) wr($urandom_range(0, 9), $urandom_range(0, 19), 3'($urandom_range(1, 7)));
      else rand_px();
      if (busy) hi++;
    end
    n_checks++;
    if (hi != 200) begin n_fail++; $display("FAIL restart_busy_len got=%0d exp=200", hi); end
    scan_board();
  endtask

  task automatic test_frame_sync();
    int ticks;
    logic hs, vs, von;
    int y;
    ticks = 0;
    for (int f = 0; f < 2; f++)
      for (int line = 0; line < 525; line++)
        for (int c = 0; c < 4; c++) begin
          hs  = (c != 3);
          vs  = !(line == 490 || line == 491);
          von = (line < 480) && (c < 2);
          y   = (line < 480) ? line : 0;
          step($urandom_range(230, 410), y, von, hs, vs, 1'b0, 0, 0, 3'd0, 1'b0);
          if (frame_tick) ticks++;
        end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 3'd0, 1'b0);
      if (frame_tick) ticks++;
    end
    n_checks++;
    if (ticks != 2) begin n_fail++; $display("FAIL frame_tick_count got=%0d exp=2", ticks); end
  endtask

  task automatic test_reset_mid();
    step(300, 150, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3'd0, 1'b1);
    for (int i = 0; i < 50; i++) rand_px();
    for (int i = 0; i < 3; i++) step(238, 80, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3'd0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    set_idle();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    init_model();
    test_sweep_after_reset("midreset");
    scan_board();
  endtask

  initial begin
    init_model();
    test_reset();
    test_sweep_after_reset("reset");
    test_write_basic();
    test_bad_writes();
    test_border();
    test_clear_restart();
    test_frame_sync();
    test_reset_mid();
    repeat (3) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 3'd0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
